// File: rtl/register_file_pkg.sv
// Shared constants for the register file and the ALU/CPU datapath that sits around it.
package register_file_pkg;

  localparam int unsigned ZERO_ADDR = 0;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = 5;

endpackage

// File: rtl/register_file_mux_pow2.sv
// Power-of-two N-bit wide selector: one of 2**L inputs chosen by an L-bit select.
module mux_pow2
  import register_file_pkg::*;
#(
  parameter int N = DATA_W,
  parameter int L = ADDR_W
) (
  input  logic [N-1:0] data [1<<L],
  input  logic [L-1:0] sel,
  output logic [N-1:0] out
);

  always_comb begin
    out = data[sel];
  end

endmodule

// File: rtl/register_file.sv
// 2**L x N register file: one write port, two combinational read ports with
// optional write forwarding and hard-wired zero register.
module register_file
  import register_file_pkg::*;
#(
  parameter int N        = DATA_W,
  parameter int L        = ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_ena,
  input  logic [L-1:0] wr_addr,
  input  logic [N-1:0] wr_data,
  input  logic [L-1:0] rd_addr0,
  output logic [N-1:0] rd_data0,
  input  logic [L-1:0] rd_addr1,
  output logic [N-1:0] rd_data1
);

  localparam int unsigned DEPTH = 1 << L;

  logic [N-1:0] regs [DEPTH];
  logic [N-1:0] mux0;
  logic [N-1:0] mux1;
  logic         wr_live;

  always_comb begin
    wr_live = wr_ena && !((ZERO_REG != 0) && (wr_addr == L'(ZERO_ADDR)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_live) begin
      regs[wr_addr] <= wr_data;
    end
  end

  mux_pow2 #(.N(N), .L(L)) u_mux0 (
    .data (regs),
    .sel  (rd_addr0),
    .out  (mux0)
  );

  mux_pow2 #(.N(N), .L(L)) u_mux1 (
    .data (regs),
    .sel  (rd_addr1),
    .out  (mux1)
  );

  // Priority after the mux: reset and zero-register masking override forwarding.
  function automatic logic [N-1:0] port_read(input logic [L-1:0] addr,
                                              input logic [N-1:0] stored);
    if (rst || ((ZERO_REG != 0) && (addr == L'(ZERO_ADDR)))) begin
      return '0;
    end else if ((BYPASS != 0) && wr_live && (addr == wr_addr)) begin
      return wr_data;
    end else begin
      return stored;
    end
  endfunction

  always_comb begin
    rd_data0 = port_read(rd_addr0, mux0);
    rd_data1 = port_read(rd_addr1, mux1);
  end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: default instance, a non-forwarding
// instance and a narrow 8-bit x 8-entry instance.
module tb_register_file;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;

  logic        wr_ena;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr0;
  logic [31:0] rd_data0;
  logic [4:0]  rd_addr1;
  logic [31:0] rd_data1;

  logic        b_wr_ena;
  logic [4:0]  b_wr_addr;
  logic [31:0] b_wr_data;
  logic [4:0]  b_rd_addr0;
  logic [31:0] b_rd_data0;
  logic [4:0]  b_rd_addr1;
  logic [31:0] b_rd_data1;

  logic        s_wr_ena;
  logic [2:0]  s_wr_addr;
  logic [7:0]  s_wr_data;
  logic [2:0]  s_rd_addr0;
  logic [7:0]  s_rd_data0;
  logic [2:0]  s_rd_addr1;
  logic [7:0]  s_rd_data1;

  int tests = 0;
  int fails = 0;
  logic [31:0] sb [32];

  register_file dut (
    .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr0(rd_addr0), .rd_data0(rd_data0), .rd_addr1(rd_addr1), .rd_data1(rd_data1)
  );

  register_file #(.BYPASS(0)) dut_nobyp (
    .clk(clk), .rst(rst), .wr_ena(b_wr_ena), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rd_addr0(b_rd_addr0), .rd_data0(b_rd_data0), .rd_addr1(b_rd_addr1), .rd_data1(b_rd_data1)
  );

  register_file #(.N(8), .L(3)) dut_small (
    .clk(clk), .rst(rst), .wr_ena(s_wr_ena), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .rd_addr0(s_rd_addr0), .rd_data0(s_rd_data0), .rd_addr1(s_rd_addr1), .rd_data1(s_rd_data1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    wr_ena = 1'b0; wr_addr = '0; wr_data = '0; rd_addr0 = '0; rd_addr1 = '0;
    b_wr_ena = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_rd_addr0 = '0; b_rd_addr1 = '0;
    s_wr_ena = 1'b0; s_wr_addr = '0; s_wr_data = '0; s_rd_addr0 = '0; s_rd_addr1 = '0;

    // Power-on reset pulse
    #2 rst = 1'b1;
    #1 check("rst_pulse_rd0", rd_data0, 32'h0);
    tick();
    tick();
    rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      rd_addr0 = 5'(i);
      rd_addr1 = 5'(31 - i);
      #1;
      check($sformatf("reset_sweep_rd0_a%0d", i), rd_data0, 32'h0);
      check($sformatf("reset_sweep_rd1_a%0d", 31 - i), rd_data1, 32'h0);
    end
    b_rd_addr0 = 5'd7;
    s_rd_addr0 = 3'd7;
    #1;
    check("reset_nobyp_rd0", b_rd_data0, 32'h0);
    check("reset_small_rd0", {24'h0, s_rd_data0}, 32'h0);

    // Write 0xDEADBEEF to addr 5: forwarded in the write cycle, stored after
    tick();
    wr_ena = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    rd_addr0 = 5'd5; rd_addr1 = 5'd5;
    #1;
    check("bypass_rd0_a5", rd_data0, 32'hDEADBEEF);
    check("bypass_rd1_a5", rd_data1, 32'hDEADBEEF);
    tick();
    wr_ena = 1'b0; wr_data = 32'h0;
    #1;
    check("stored_rd0_a5", rd_data0, 32'hDEADBEEF);
    check("stored_rd1_a5", rd_data1, 32'hDEADBEEF);

    // Writes to register 0 are discarded and never forwarded
    wr_ena = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
    rd_addr0 = 5'd0; rd_addr1 = 5'd0;
    #1;
    check("zero_during_rd0", rd_data0, 32'h0);
    check("zero_during_rd1", rd_data1, 32'h0);
    tick();
    wr_ena = 1'b0;
    #1;
    check("zero_after_rd0", rd_data0, 32'h0);
    check("zero_after_rd1", rd_data1, 32'h0);

    // Fill 1..31 and sweep ports in opposite directions
    sb[0] = 32'h0;
    for (int i = 1; i < 32; i++) begin
      sb[i] = $urandom;
      wr_ena = 1'b1; wr_addr = 5'(i); wr_data = sb[i];
      tick();
    end
    wr_ena = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rd_addr0 = 5'(i);
      rd_addr1 = 5'(31 - i);
      #1;
      check($sformatf("fill_rd0_a%0d", i), rd_data0, sb[i]);
      check($sformatf("fill_rd1_a%0d", 31 - i), rd_data1, sb[31 - i]);
    end

    // Non-forwarding instance: old value until the write edge
    b_wr_ena = 1'b1; b_wr_addr = 5'd3; b_wr_data = 32'h11111111;
    tick();
    b_wr_data = 32'h22222222;
    b_rd_addr0 = 5'd3; b_rd_addr1 = 5'd3;
    #1;
    check("nobyp_old_rd0", b_rd_data0, 32'h11111111);
    check("nobyp_old_rd1", b_rd_data1, 32'h11111111);
    tick();
    b_wr_ena = 1'b0;
    #1;
    check("nobyp_new_rd0", b_rd_data0, 32'h22222222);
    check("nobyp_new_rd1", b_rd_data1, 32'h22222222);

    // Asynchronous reset mid-cycle with a write pending
    tick();
    #2;
    rst = 1'b1;
    wr_ena = 1'b1; wr_addr = 5'd9; wr_data = 32'hCAFEF00D;
    rd_addr0 = 5'd9; rd_addr1 = 5'd31;
    #1;
    check("async_rst_bypass_masked", rd_data0, 32'h0);
    check("async_rst_rd1_a31", rd_data1, 32'h0);
    rd_addr1 = 5'd1;
    #1;
    check("async_rst_rd1_a1", rd_data1, 32'h0);
    check("async_rst_nobyp_a3", b_rd_data0, 32'h0);
    tick();
    rst = 1'b0;
    wr_ena = 1'b0;
    #1;
    check("write_under_rst_ignored", rd_data0, 32'h0);
    wr_ena = 1'b1;
    tick();
    wr_ena = 1'b0;
    rd_addr1 = 5'd10;
    #1;
    check("write_after_rst_applied", rd_data0, 32'hCAFEF00D);
    check("neighbour_still_clear", rd_data1, 32'h0);

    // Narrow instance N=8, L=3
    s_wr_ena = 1'b1; s_wr_addr = 3'd7; s_wr_data = 8'hA5;
    tick();
    s_wr_addr = 3'd1; s_wr_data = 8'h3C;
    tick();
    s_wr_ena = 1'b0;
    s_rd_addr0 = 3'd7; s_rd_addr1 = 3'd1;
    #1;
    check("small_rd0_a7", {24'h0, s_rd_data0}, 32'h000000A5);
    check("small_rd1_a1", {24'h0, s_rd_data1}, 32'h0000003C);
    for (int i = 2; i < 7; i++) begin
      s_rd_addr0 = 3'(i);
      s_rd_addr1 = 3'(i);
      #1;
      check($sformatf("small_unwritten_rd0_a%0d", i), {24'h0, s_rd_data0}, 32'h0);
      check($sformatf("small_unwritten_rd1_a%0d", i), {24'h0, s_rd_data1}, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
